rv_regfile_seq: RTL and testbench



---
 rtl/rv_regfile_pkg.sv | 24 ++
 rtl/regfile_bram_sdp.sv | 21 ++
 rtl/rv_regfile_seq.sv | 159 +++++++++++++++
 tb/tb_rv_regfile_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_regfile_pkg.sv
// Shared types and helpers for the sequential RV register file.
package rv_regfile_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam int ZERO_REG = 0;

    function automatic int beats(input int xlen, input int bram_w);
        return xlen / bram_w;
    endfunction

    // RAM word address of one beat: {beat, reg}.
    function automatic int unsigned beat_addr(input int unsigned beat,
                                              input int unsigned reg_idx,
                                              input int unsigned reg_bits);
        return (beat << reg_bits) | reg_idx;
    endfunction

endpackage

// File: rtl/regfile_bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module regfile_bram_sdp #(
    parameter int BRAM_W = 16,
    parameter int RAM_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_waddr,
    input  logic [BRAM_W-1:0] i_wdata,
    input  logic [RAM_AW-1:0] i_raddr,
    output logic [BRAM_W-1:0] o_rdata
);

    logic [BRAM_W-1:0] r_mem [2**RAM_AW];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/rv_regfile_seq.sv
// Sequential register file: each XLEN register is stored as BEATS narrow RAM words.
// state | meaning
// INIT  | zeroing RAM words 0..NUM_REGS*BEATS-1, requests ignored
// IDLE  | ready; write wins over read
// WRITE | one RAM write per beat of rd (none for x0)
// READ  | 2*BEATS RAM reads (rs1 beats then rs2 beats), captured one cycle later
module rv_regfile_seq
    import rv_regfile_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BRAM_W         = 16,
    parameter int NUM_REGS       = 32,
    parameter int RAM_AW         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rd_req,
    output logic            o_rd_ready,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rd_valid,
    input  logic            i_wr_req,
    output logic            o_wr_ready,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_wr_data,
    output logic            o_wr_done
);

    localparam int BEATS     = beats(XLEN, BRAM_W);
    localparam int RB        = $clog2(NUM_REGS);
    localparam int CW        = $clog2(2 * BEATS + 1);
    localparam int SHW       = 2 * XLEN - BRAM_W;
    localparam int INIT_LAST = NUM_REGS * BEATS - 1;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [RAM_AW-1:0]  r_init_addr;
    logic [RB-1:0]      r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0]    r_wdata;
    logic [SHW-1:0]     r_shift;

    logic               w_wr_accept, w_rd_accept;
    logic               w_wr_last, w_rd_last;
    logic               w_ram_we;
    logic [RAM_AW-1:0]  w_ram_waddr, w_ram_raddr;
    logic [BRAM_W-1:0]  w_ram_wdata, w_ram_rdata;
    logic [CW-1:0]      w_rd_beat;
    logic [RB-1:0]      w_rd_reg;
    logic [2*XLEN-1:0]  w_full;

    assign w_wr_accept = (r_state == IDLE) && i_wr_req && o_wr_ready;
    assign w_rd_accept = (r_state == IDLE) && i_rd_req && o_rd_ready && !i_wr_req;
    // Completed read image: newest beat on top, rs1 beat 0 at the bottom.
    assign w_full      = {w_ram_rdata, r_shift};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_last   = 1'b0;
        w_rd_last   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_waddr = '0;
        w_ram_wdata = '0;
        w_ram_raddr = '0;
        w_rd_beat   = (r_cnt < CW'(BEATS)) ? r_cnt : r_cnt - CW'(BEATS);
        w_rd_reg    = (r_cnt < CW'(BEATS)) ? r_rs1 : r_rs2;
        case (r_state)
            INIT: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_init_addr;
                if (r_init_addr == RAM_AW'(INIT_LAST)) w_state_nxt = IDLE;
            end
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_wr_accept)      w_state_nxt = WRITE;
                else if (w_rd_accept) w_state_nxt = READ;
            end
            WRITE: begin
                w_ram_we    = (r_rd != RB'(ZERO_REG));
                w_ram_waddr = RAM_AW'(beat_addr(32'(r_cnt), 32'(r_rd), RB));
                w_ram_wdata = r_wdata[BRAM_W-1:0];
                if (r_rd == RB'(ZERO_REG) || r_cnt == CW'(BEATS - 1)) begin
                    w_wr_last   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            READ: begin
                w_ram_raddr = RAM_AW'(beat_addr(32'(w_rd_beat), 32'(w_rd_reg), RB));
                if (r_cnt == CW'(2 * BEATS)) begin
                    w_rd_last   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
            r_cnt       <= '0;
            r_init_addr <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            o_rd_ready  <= (CLEAR_ON_RESET == 0);
            o_wr_ready  <= (CLEAR_ON_RESET == 0);
            o_rd_valid  <= 1'b0;
            o_wr_done   <= 1'b0;
            o_rs1_data  <= '0;
            o_rs2_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            o_rd_ready <= (w_state_nxt == IDLE);
            o_wr_ready <= (w_state_nxt == IDLE);
            o_wr_done  <= w_wr_last;
            o_rd_valid <= w_rd_last;
            if (r_state == INIT) r_init_addr <= r_init_addr + 1'b1;
            if (w_wr_accept) begin
                r_rd    <= i_rd_addr[RB-1:0];
                r_wdata <= i_wr_data;
            end else if (r_state == WRITE) begin
                r_wdata <= r_wdata >> BRAM_W;
            end
            if (w_rd_accept) begin
                r_rs1 <= i_rs1_addr[RB-1:0];
                r_rs2 <= i_rs2_addr[RB-1:0];
            end
            if (r_state == READ && r_cnt != '0) r_shift <= w_full[2*XLEN-1:BRAM_W];
            if (w_rd_last) begin
                o_rs1_data <= (r_rs1 == RB'(ZERO_REG)) ? '0 : w_full[XLEN-1:0];
                o_rs2_data <= (r_rs2 == RB'(ZERO_REG)) ? '0 : w_full[2*XLEN-1:XLEN];
            end
        end
    end

    regfile_bram_sdp #(
        .BRAM_W (BRAM_W),
        .RAM_AW (RAM_AW)
    ) u_bram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_rv_regfile_seq.sv
// Bench for rv_regfile_seq: default 16-bit RAM instance plus a 32-bit (single beat) instance.
module tb_rv_regfile_seq;

    localparam int BEATS0 = 32 / 16;
    localparam int BEATS1 = 32 / 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req   [2];
    logic        wr_req   [2];
    logic [4:0]  rs1_addr [2];
    logic [4:0]  rs2_addr [2];
    logic [4:0]  rd_addr  [2];
    logic [31:0] wr_data  [2];
    logic        rd_ready [2];
    logic        wr_ready [2];
    logic        rd_valid [2];
    logic        wr_done  [2];
    logic [31:0] rs1_data [2];
    logic [31:0] rs2_data [2];

    logic [31:0] model [2][32];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_regfile_seq #(.XLEN(32), .BRAM_W(16), .NUM_REGS(32), .RAM_AW(8), .CLEAR_ON_RESET(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rd_req(rd_req[0]), .o_rd_ready(rd_ready[0]),
        .i_rs1_addr(rs1_addr[0]), .i_rs2_addr(rs2_addr[0]),
        .o_rs1_data(rs1_data[0]), .o_rs2_data(rs2_data[0]), .o_rd_valid(rd_valid[0]),
        .i_wr_req(wr_req[0]), .o_wr_ready(wr_ready[0]),
        .i_rd_addr(rd_addr[0]), .i_wr_data(wr_data[0]), .o_wr_done(wr_done[0])
    );

    rv_regfile_seq #(.XLEN(32), .BRAM_W(32), .NUM_REGS(32), .RAM_AW(8), .CLEAR_ON_RESET(1)) dut32 (
        .i_clk(clk), .i_rst(rst),
        .i_rd_req(rd_req[1]), .o_rd_ready(rd_ready[1]),
        .i_rs1_addr(rs1_addr[1]), .i_rs2_addr(rs2_addr[1]),
        .o_rs1_data(rs1_data[1]), .o_rs2_data(rs2_data[1]), .o_rd_valid(rd_valid[1]),
        .i_wr_req(wr_req[1]), .o_wr_ready(wr_ready[1]),
        .i_rd_addr(rd_addr[1]), .i_wr_data(wr_data[1]), .o_wr_done(wr_done[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wr_lat(input int s, input logic [4:0] a);
        if (a == 5'd0) return 1;
        return (s == 0) ? BEATS0 : BEATS1;
    endfunction

    function automatic int rd_lat(input int s);
        return 2 * ((s == 0) ? BEATS0 : BEATS1) + 1;
    endfunction

    function automatic logic [31:0] ref_val(input int s, input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[s][a];
    endfunction

    task automatic wait_ready(input int s);
        int n = 0;
        while (!(rd_ready[s] && wr_ready[s]) && n < 200) begin
            tick();
            n++;
        end
        check("ready_wait", {62'd0, rd_ready[s], wr_ready[s]}, 64'd3);
    endtask

    task automatic do_write(input int s, input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        wait_ready(s);
        wr_req[s] = 1'b1; rd_addr[s] = a; wr_data[s] = d;
        tick();
        wr_req[s] = 1'b0; rd_addr[s] = 5'($urandom); wr_data[s] = $urandom;
        do begin
            tick();
            n++;
        end while (!wr_done[s] && n < 20);
        check($sformatf("wr_lat x%0d", a), 64'(n), 64'(wr_lat(s, a)));
        if (a != 5'd0) model[s][a] = d;
    endtask

    task automatic do_read(input int s, input logic [4:0] a1, input logic [4:0] a2);
        int n = 0;
        wait_ready(s);
        rd_req[s] = 1'b1; rs1_addr[s] = a1; rs2_addr[s] = a2;
        tick();
        rd_req[s] = 1'b0; rs1_addr[s] = 5'($urandom); rs2_addr[s] = 5'($urandom);
        do begin
            tick();
            n++;
        end while (!rd_valid[s] && n < 20);
        check("rd_lat", 64'(n), 64'(rd_lat(s)));
        check($sformatf("rs1 x%0d", a1), 64'(rs1_data[s]), 64'(ref_val(s, a1)));
        check($sformatf("rs2 x%0d", a2), 64'(rs2_data[s]), 64'(ref_val(s, a2)));
    endtask

    initial begin
        int n;
        int vcount;
        for (int s = 0; s < 2; s++) begin
            rd_req[s] = 1'b0; wr_req[s] = 1'b0;
            rs1_addr[s] = '0; rs2_addr[s] = '0; rd_addr[s] = '0; wr_data[s] = '0;
            for (int r = 0; r < 32; r++) model[s][r] = 32'h0;
        end
        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_rd_ready", 64'(rd_ready[0]), 64'd0);
        check("rst_wr_ready", 64'(wr_ready[0]), 64'd0);
        check("rst_rd_valid", 64'(rd_valid[0]), 64'd0);
        check("rst_wr_done", 64'(wr_done[0]), 64'd0);
        check("rst_rs_data", {rs1_data[0], rs2_data[0]}, 64'd0);

        rst = 1'b0;
        n = 0;
        while (!rd_ready[0] && n < 200) begin
            tick();
            n++;
        end
        check("init_cycles", 64'(n), 64'd64);
        check("init_wr_ready", 64'(wr_ready[0]), 64'd1);

        do_read(0, 5'd5, 5'd6);
        do_write(0, 5'd5, 32'hDEADBEEF);
        do_read(0, 5'd5, 5'd0);
        tick(); tick(); tick();
        check("rs1_held", 64'(rs1_data[0]), 64'hDEADBEEF);

        do_write(0, 5'd0, 32'hFFFFFFFF);
        do_read(0, 5'd0, 5'd0);

        // Simultaneous read and write of x7: write first, read follows.
        do_write(0, 5'd7, 32'h11111111);
        wait_ready(0);
        rd_req[0] = 1'b1; rs1_addr[0] = 5'd7; rs2_addr[0] = 5'd0;
        wr_req[0] = 1'b1; rd_addr[0] = 5'd7; wr_data[0] = 32'h22222222;
        tick();
        wr_req[0] = 1'b0; wr_data[0] = 32'h0;
        n = 0; vcount = 0;
        do begin
            tick();
            n++;
            vcount += int'(rd_valid[0]);
        end while (!wr_done[0] && n < 20);
        check("simul_wr_lat", 64'(n), 64'd2);
        check("simul_no_early_valid", 64'(vcount), 64'd0);
        model[0][7] = 32'h22222222;
        check("simul_rd_ready", 64'(rd_ready[0]), 64'd1);
        tick();
        rd_req[0] = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_valid[0] && n < 20);
        check("simul_rd_lat", 64'(n), 64'd5);
        check("simul_rs1", 64'(rs1_data[0]), 64'h22222222);

        // Reset on cycle 3 of a read.
        wait_ready(0);
        rd_req[0] = 1'b1; rs1_addr[0] = 5'd5; rs2_addr[0] = 5'd7;
        tick();
        rd_req[0] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst_data", {rs1_data[0], rs2_data[0]}, 64'd0);
        check("midrst_ready", 64'(rd_ready[0]), 64'd0);
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vcount += int'(rd_valid[0]);
        end
        rst = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 32; r++) model[s][r] = 32'h0;
        n = 0;
        while (!rd_ready[0] && n < 200) begin
            tick();
            n++;
            vcount += int'(rd_valid[0]);
        end
        check("midrst_init_cycles", 64'(n), 64'd64);
        check("midrst_no_valid", 64'(vcount), 64'd0);
        check("midrst_data_after", {rs1_data[0], rs2_data[0]}, 64'd0);
        do_write(0, 5'd9, 32'h12345678);
        do_read(0, 5'd9, 5'd5);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] a1, a2;
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) do_write(0, a1, $urandom);
            else                           do_read(0, a1, a2);
        end

        do_write(1, 5'd31, 32'hA5A5A5A5);
        do_read(1, 5'd31, 5'd0);
        for (int i = 0; i < 10; i++) begin
            logic [4:0] a1, a2;
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) do_write(1, a1, $urandom);
            else                           do_read(1, a1, a2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
